mac_share_arbiter: RTL and testbench

MAC_SHARE_ARBITER -- requirements
Module: mac_share_arbiter

---
 rtl/mac_share_arbiter.sv | 95 +++++++++
 tb/tb_mac_share_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: round-robin arbiter sharing one pipelined fixed-point MAC among FIR requesters
module mac_share_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 10,
    localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            op_valid,
    input  logic [NUM_REQ-1:0]            op_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] op_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] op_b,
    output logic [NUM_REQ-1:0]            op_ready,
    output logic [DATA_WIDTH-1:0]         res_data,
    output logic [NUM_REQ-1:0]            res_valid,
    input  logic [NUM_REQ-1:0]            res_ack,
    output logic                          busy,
    output logic [GW-1:0]                 grant_id
);
    typedef enum logic [1:0] {IDLE, GRANT, DRAIN, RESULT} state_t;
    localparam int PW = 2 * DATA_WIDTH;
    state_t                       state;
    logic [GW-1:0]                g, rr_ptr, pick, nxt;
    logic                         pick_ok, s1_v;
    logic signed [DATA_WIDTH-1:0] a_g, b_g, p, s1, acc;
    logic signed [PW-1:0]         prod;
    logic [NUM_REQ-1:0]           g_oh;

    assign g_oh      = NUM_REQ'(1) << g;
    assign a_g       = op_a[int'(g)*DATA_WIDTH +: DATA_WIDTH];
    assign b_g       = op_b[int'(g)*DATA_WIDTH +: DATA_WIDTH];
    assign prod      = PW'(a_g) * PW'(b_g);
    assign p         = DATA_WIDTH'(prod >>> FRAC_BITS);
    assign nxt       = GW'((int'(g) + 1) % NUM_REQ);
    assign op_ready  = (state == GRANT) ? g_oh : '0;
    assign res_valid = (state == RESULT) ? g_oh : '0;
    assign res_data  = (state == RESULT) ? acc : '0;
    assign busy      = state != IDLE;
    assign grant_id  = g;

    // first requesting index at or above rr_ptr, wrapping; lowest offset wins
    always_comb begin
        pick_ok = 1'b0;
        pick    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick_ok = 1'b1;
                pick    = GW'((int'(rr_ptr) + k) % NUM_REQ);
            end
    end

    // control FSM plus two-stage multiply / accumulate pipeline
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
            g      <= '0;
            acc    <= '0;
            s1     <= '0;
            s1_v   <= 1'b0;
        end else begin
            s1_v <= 1'b0;
            if (s1_v) acc <= acc + s1;
            case (state)
                IDLE: begin
                    acc <= '0;
                    if (pick_ok) begin
                        g     <= pick;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[g]) begin
                        rr_ptr <= nxt;
                        state  <= IDLE;
                    end else if (op_valid[g]) begin
                        s1   <= p;
                        s1_v <= 1'b1;
                        if (op_last[g]) state <= DRAIN;
                    end
                end
                DRAIN: state <= RESULT;
                RESULT: begin
                    if (res_ack[g]) begin
                        rr_ptr <= nxt;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_share_arbiter.sv
// tb_mac_share_arbiter: vector table plus scoreboard checks for the shared MAC arbiter
module tb_mac_share_arbiter;
    localparam int N = 4;
    localparam int W = 32;

    typedef struct packed {
        logic [1:0]        id;
        logic [1:0]        n;
        logic [3:0]        hold;
        logic [2:0][W-1:0] a;
        logic [2:0][W-1:0] b;
        logic [W-1:0]      exp;
    } vec_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0, op_valid = '0, op_last = '0, res_ack = '0;
    logic [N*W-1:0] op_a = '0, op_b = '0;
    logic [N-1:0]   op_ready, res_valid;
    logic [W-1:0]   res_data;
    logic           busy;
    logic [1:0]     grant_id;
    int             n_cmp = 0, n_bad = 0;
    logic [W-1:0]   sb[$];
    vec_t           vecs[7];

    always #5 clock = ~clock;

    mac_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .FRAC_BITS(10)) dut (
        .clock(clock), .reset(reset), .req(req), .op_valid(op_valid), .op_last(op_last),
        .op_a(op_a), .op_b(op_b), .op_ready(op_ready), .res_data(res_data),
        .res_valid(res_valid), .res_ack(res_ack), .busy(busy), .grant_id(grant_id)
    );

    function automatic vec_t mk(input int id, input int n, input int hold,
                                input logic [W-1:0] a0, b0, a1, b1, a2, b2, exp);
        vec_t v;
        v.id = 2'(id); v.n = 2'(n); v.hold = 4'(hold);
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_ops(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        for (int i = 0; i < N; i++) begin
            op_a[i*W +: W] = (i == id) ? a : W'($urandom);
            op_b[i*W +: W] = (i == id) ? b : W'($urandom);
        end
    endtask

    task automatic wait_grant(input int id, output int k);
        k = 0;
        while (op_ready == '0 && k < 20) begin
            tick;
            k++;
        end
        chk("grant_ready", 32'(op_ready), 32'(N'(1) << id));
        chk("grant_id", 32'(grant_id), 32'(id));
    endtask

    task automatic run_burst(input vec_t v);
        logic [N-1:0] oh;
        logic [W-1:0] exp;
        int k, n;
        oh = N'(1) << v.id;
        n = int'(v.n);
        req = oh;
        wait_grant(int'(v.id), k);
        chk("grant_latency", 32'(k), 32'd1);
        for (int j = 0; j < n; j++) begin
            op_valid = '1;
            op_last = (j == n - 1) ? '1 : ~oh;
            res_ack = ~oh;
            drive_ops(int'(v.id), v.a[j], v.b[j]);
            if (j == n - 1) sb.push_back(v.exp);
            tick;
        end
        op_valid = '0; op_last = '0; res_ack = '0;
        chk("drain_res_valid", 32'(res_valid), 32'd0);
        chk("drain_busy", 32'(busy), 32'd1);
        tick;
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        chk("res_valid", 32'(res_valid), 32'(oh));
        chk("res_data", res_data, exp);
        for (int h = 0; h < int'(v.hold); h++) begin
            res_ack = ~oh;
            tick;
            res_ack = '0;
            chk("hold_valid", 32'(res_valid), 32'(oh));
            chk("hold_data", res_data, exp);
            chk("hold_ready", 32'(op_ready), 32'd0);
        end
        res_ack = oh;
        tick;
        res_ack = '0;
        req = '0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_res_valid", 32'(res_valid), 32'd0);
        chk("idle_res_data", res_data, 32'd0);
    endtask

    initial begin
        int k;
        vecs[0] = mk(0, 3, 10, 32'h400, 32'h800, 32'h400, 32'h800, 32'h400, 32'h800, 32'h1800);
        vecs[1] = mk(1, 1, 0, 32'hFFFFFC00, 32'h5, 0, 0, 0, 0, 32'hFFFFFFFB);
        vecs[2] = mk(2, 1, 0, 32'hFFFFFC00, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h1);
        vecs[3] = mk(3, 2, 0, 32'hC00, 32'hFFFFF800, 32'h200, 32'h600, 0, 0, 32'hFFFFEB00);
        vecs[4] = mk(0, 2, 0, 32'h40000000, 32'hC00, 32'h40000000, 32'hC00, 0, 0, 32'h80000000);
        vecs[5] = mk(1, 1, 0, 32'hFFFFFC01, 32'h1, 0, 0, 0, 0, 32'hFFFFFFFF);
        vecs[6] = mk(2, 1, 2, 32'h400, 32'h7, 0, 0, 0, 0, 32'h7);

        #2;
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        #5 reset = 1'b0;
        tick;

        foreach (vecs[i]) run_burst(vecs[i]);

        reset = 1'b1;
        req = '1;
        tick;
        reset = 1'b0;
        for (int r = 0; r < 5; r++) begin
            wait_grant(r % N, k);
            for (int j = 0; j < 2; j++) begin
                op_valid = '1;
                op_last = (j == 1) ? '1 : '0;
                drive_ops(r % N, 32'h400, 32'h400);
                chk("rr_onehot", 32'($countones(op_ready)), 32'd1);
                tick;
            end
            op_valid = '0; op_last = '0;
            tick;
            chk("rr_res_valid", 32'(res_valid), 32'(N'(1) << (r % N)));
            chk("rr_res_data", res_data, 32'h800);
            res_ack = '1;
            if (r == 4) req = '0;
            tick;
            res_ack = '0;
        end
        tick;

        req = 4'b0100;
        wait_grant(2, k);
        op_valid = '1;
        drive_ops(2, 32'h400, 32'h400);
        tick;
        op_valid = '0;
        req = 4'b1001;
        tick;
        chk("abort2_busy", 32'(busy), 32'd0);
        chk("abort2_res_valid", 32'(res_valid), 32'd0);
        tick;
        chk("after_abort2_grant", 32'(grant_id), 32'd3);
        chk("after_abort2_ready", 32'(op_ready), 32'b1000);
        req = 4'b0100;
        tick;
        chk("abort3_busy", 32'(busy), 32'd0);
        tick;
        chk("regrant2", 32'(grant_id), 32'd2);
        req = 4'b0001;
        tick;
        tick;
        chk("wrap_grant0", 32'(grant_id), 32'd0);
        chk("wrap_ready0", 32'(op_ready), 32'b0001);
        req = '0;
        tick;
        tick;
        chk("abort_no_result", 32'(res_valid), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        req = 4'b0001;
        wait_grant(0, k);
        for (int j = 0; j < 5; j++) begin
            op_valid = '1;
            drive_ops(0, 32'h400, 32'h800);
            tick;
        end
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(op_ready), 32'd0);
        chk("midrst_grant_id", 32'(grant_id), 32'd0);
        op_valid = '0;
        req = '0;
        #2 reset = 1'b0;
        tick;
        chk("midrst_no_result", 32'(res_valid), 32'd0);
        run_burst(mk(0, 1, 0, 32'h400, 32'h7, 0, 0, 0, 0, 32'h7));

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
